// File: rtl/nm_rx_deframer.sv
// NM link receive deframer: serial start/data/parity/stop frames into a fall-through word FIFO.
// One instance per NM channel; the FIFO is drained by the PDMA channel.
module nm_rx_deframer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RDY_THRESH = 8
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     ENABLE,
  input  logic                     N2C_DATA,
  input  logic                     RD_EN,
  input  logic                     CLR_FLAGS,
  output logic [DATA_W-1:0]        RD_DATA,
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
  output logic                     PDMA_DATA_RDY,
  output logic                     OVERFLOW,
  output logic [7:0]               ERR_CNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(DATA_W) + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  // ---------------------------------------------------------------------------
  // Deframer
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_ok_q, parity_ok_d;
  logic              frame_good;
  logic              frame_bad;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_ok_d = parity_ok_q;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
    // Dropping ENABLE abandons the frame silently; it is not a line error.
    if (!ENABLE) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (N2C_DATA) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {shift_q[DATA_W-2:0], N2C_DATA};
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(DATA_W - 1)) begin
            state_d = StParity;
          end
        end
        StParity: begin
          parity_ok_d = ~(^{shift_q, N2C_DATA});
          state_d     = StStop;
        end
        StStop: begin
          if (!N2C_DATA && parity_ok_q) begin
            frame_good = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_ok_q <= parity_ok_d;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              empty, full, push, pop, drop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign pop   = RD_EN && !empty;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign push  = frame_good && (!full || pop);
  assign drop  = frame_good && full && !pop;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------------
  logic       rdy_q, rdy_d;
  logic       ovf_q, ovf_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    rdy_d     = (level_d >= LW'(RDY_THRESH));
    ovf_d     = ovf_q | drop;
    err_cnt_d = err_cnt_q;
    if (frame_bad && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
    if (CLR_FLAGS) begin
      ovf_d     = 1'b0;
      err_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rdy_q     <= 1'b0;
      ovf_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      rdy_q     <= rdy_d;
      ovf_q     <= ovf_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign RD_DATA       = empty ? '0 : mem_q[rd_ptr_q];
  assign FIFO_LEVEL    = level_q;
  assign PDMA_DATA_RDY = rdy_q;
  assign OVERFLOW      = ovf_q;
  assign ERR_CNT       = err_cnt_q;

endmodule

// File: doc/nm_rx_deframer.md
# nm_rx_deframer

Receive front-end of the control module's neuromodulation (NM) link. Deframes the one-bit-per-clock N2C_DATA serial stream from an NM chip into DATA_W-bit sample words, checks parity and stop bit, and buffers good words in a first-word-fall-through FIFO. The FIFO is drained by the PDMA channel, which is woken by PDMA_DATA_RDY. One instance exists per NM channel (N2C_DATA_0, N2C_DATA_1).

## Interface
- DATA_W, 16, payload bits per frame
- DEPTH, 16, FIFO depth in words (power of 2, ≥2)
- RDY_THRESH, 8, FIFO level at which PDMA_DATA_RDY asserts (1..DEPTH)
- PCLK  in  1  system clock, all logic on rising edge
- PRESET  in  1  asynchronous, active-high reset
- ENABLE  in  1  receiver enable; low aborts any frame in progress
- N2C_DATA  in  1  serial data from NM chip, one bit per PCLK, idle low
- RD_EN  in  1  pop head word; ignored when empty
- RD_DATA  out  DATA_W  FIFO head word (fall-through); 0 when empty
- FIFO_LEVEL  out  $clog2(DEPTH)+1  words currently stored
- PDMA_DATA_RDY  out  1  registered, high while FIFO_LEVEL ≥ RDY_THRESH
- OVERFLOW  out  1  sticky: good word dropped because FIFO was full
- ERR_CNT  out  8  saturating count of parity and framing errors
- CLR_FLAGS  in  1  one-cycle pulse; clears OVERFLOW and ERR_CNT

## Operation
- Frame: start bit 1, DATA_W data bits MSB first, even-parity bit, stop bit 0; total DATA_W+3 bits.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: if ENABLE and N2C_DATA=1 → DATA, bit counter = 0.
- DATA: shift N2C_DATA into shift register; after DATA_W bits → PARITY.
- PARITY: latch parity_ok = (XOR of data bits and parity bit) == 0 → STOP.
- STOP: if N2C_DATA=0 and parity_ok, push word; otherwise discard and increment ERR_CNT. Both paths → IDLE.
- Back-to-back frames: a start bit is accepted in the cycle immediately after a stop bit.
- ENABLE low in any state: → IDLE next edge, partial word discarded, no error counted.
- FIFO: push and pop in the same cycle give an unchanged level and both complete, including when full.
- Push when full without pop: word dropped, OVERFLOW set.
- Pop when empty: ignored.
- ERR_CNT saturates at 255.
- CLR_FLAGS has priority over a same-cycle set or increment: the result is 0.
- Reset: FSM IDLE, FIFO empty, and all outputs 0 (RD_DATA, FIFO_LEVEL, PDMA_DATA_RDY, OVERFLOW, ERR_CNT).

## Timing
- Cycle numbering: cycle 0 samples the start bit, cycles 1..DATA_W sample the data, DATA_W+1 samples parity, DATA_W+2 samples stop.
- The push happens at the edge ending cycle DATA_W+2.
- FIFO_LEVEL, RD_DATA and PDMA_DATA_RDY reflect the new word in cycle DATA_W+3. That is 19 cycles after the start bit for DATA_W=16.
- RD_EN in cycle n: head advances and FIFO_LEVEL decrements in cycle n+1.
- PDMA_DATA_RDY is computed from the next-state level, so it changes in the same cycle as FIFO_LEVEL. There is no extra lag.
- OVERFLOW and ERR_CNT update in cycle DATA_W+3 of the offending frame.
- Reset asserted mid-frame: all state is cleared asynchronously. After release, the line must be low before a new start bit is recognised: a 1 seen in IDLE is a start bit. Any partial frame still on the wire is therefore resynchronised by a framing error.

## Test plan
- Single frame 0xA5C3, parity 0, stop 0 → cycle 19: FIFO_LEVEL=1, RD_DATA=0xA5C3, ERR_CNT=0; RD_EN → level 0, RD_DATA=0.
- Frame 0x0001 with parity bit 0 → no push, ERR_CNT=1. A following frame 0x0001 with stop bit 1 → ERR_CNT=2. CLR_FLAGS → ERR_CNT=0.
- 8 back-to-back good frames, no reads → PDMA_DATA_RDY rises in the cycle FIFO_LEVEL becomes 8. One pop → PDMA_DATA_RDY falls with level 7.
- 17 good frames with no reads, DEPTH=16 → level 16 and OVERFLOW=1 after frame 17. Words 1..16 read back in order; word 17 is absent.
- FIFO full with RD_EN asserted on the push cycle → level stays 16, OVERFLOW stays 0, and the new word appears last in read order.
- ENABLE dropped in cycle 8 of a frame, or PRESET pulsed at cycle 10 → no push, ERR_CNT unchanged (0 after reset). The next clean frame is received correctly.
